// File: rtl/safe_seq_pkg.sv
// Shared types for the safe FSM sequencer: controller states and the downstream
// FSM's state codes.
package safe_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLR    = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } ctl_state_t;

   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam logic [1:0] S3 = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: gnt_next is the first requester at or after the pointer;
// the pointer moves just past the winner when adv is strobed.
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            adv,
   output logic [NREQ-1:0] gnt_next
);
   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] ptr_next;
   logic          found;

   always_comb begin
      gnt_next = '0;
      ptr_next = ptr_reg;
      found    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[(int'(ptr_reg) + i) % NREQ]) begin
            found                                  = 1'b1;
            gnt_next[(int'(ptr_reg) + i) % NREQ]   = 1'b1;
            ptr_next = PW'((((int'(ptr_reg) + i) % NREQ) + 1) % NREQ);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg <= '0;
      end else if (adv && found) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/safe_fsm_sequencer.sv
// Shares one serial downstream FSM between NREQ requesters: grant, optional clear,
// LSB-first shift of the pattern, then sample and report the final state code.
module safe_fsm_sequencer
   import safe_seq_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int PAT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*PAT_W-1:0] pat_i,
   input  logic [NREQ*LEN_W-1:0] len_i,
   input  logic [NREQ-1:0]       init_i,
   input  logic [NREQ*2-1:0]     exp_i,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  done,
   output logic [1:0]            result,
   output logic                  match,
   output logic                  fsm_clr,
   output logic                  fsm_din,
   input  logic [1:0]            fsm_state
);

   ctl_state_t       state_reg, state_next;
   logic [NREQ-1:0]  gnt_reg, gnt_next;
   logic [PAT_W-1:0] sh_reg, sh_next;
   logic [LEN_W-1:0] len_reg, len_next;
   logic [LEN_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       exp_reg, exp_next;
   logic [1:0]       result_reg, result_next;
   logic             match_reg, match_next;
   logic             done_reg, done_next;
   logic             clr_reg, clr_next;
   logic             din_reg, din_next;

   logic [PAT_W-1:0] pat_arr [NREQ];
   logic [LEN_W-1:0] len_arr [NREQ];
   logic [1:0]       exp_arr [NREQ];

   logic [NREQ-1:0]  win_gnt;
   logic [PAT_W-1:0] win_pat;
   logic [LEN_W-1:0] win_len;
   logic [1:0]       win_exp;
   logic             win_init;
   logic             adv;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign pat_arr[gi] = pat_i[gi*PAT_W +: PAT_W];
         assign len_arr[gi] = (len_i[gi*LEN_W +: LEN_W] > LEN_W'(PAT_W)) ?
                              LEN_W'(PAT_W) : len_i[gi*LEN_W +: LEN_W];
         assign exp_arr[gi] = exp_i[gi*2 +: 2];
      end
   endgenerate

   assign adv = (state_reg == ST_IDLE) && (|req);

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .adv      (adv),
      .gnt_next (win_gnt)
   );

   always_comb begin
      win_pat  = '0;
      win_len  = '0;
      win_exp  = '0;
      win_init = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (win_gnt[k]) begin
            win_pat  = pat_arr[k];
            win_len  = len_arr[k];
            win_exp  = exp_arr[k];
            win_init = init_i[k];
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      gnt_next    = gnt_reg;
      sh_next     = sh_reg;
      len_next    = len_reg;
      cnt_next    = cnt_reg;
      exp_next    = exp_reg;
      result_next = result_reg;
      match_next  = match_reg;
      done_next   = 1'b0;
      clr_next    = 1'b0;
      din_next    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (|req) begin
               gnt_next = win_gnt;
               len_next = win_len;
               exp_next = win_exp;
               cnt_next = '0;
               // sh_reg always holds the bits not yet placed on fsm_din
               if (win_init) begin
                  sh_next    = win_pat;
                  clr_next   = 1'b1;
                  state_next = ST_CLR;
               end else if (win_len != '0) begin
                  sh_next    = win_pat >> 1;
                  din_next   = win_pat[0];
                  state_next = ST_SHIFT;
               end else begin
                  state_next = ST_SAMPLE;
               end
            end
         end
         ST_CLR: begin
            if (len_reg != '0) begin
               din_next   = sh_reg[0];
               sh_next    = sh_reg >> 1;
               state_next = ST_SHIFT;
            end else begin
               state_next = ST_SAMPLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_reg == len_reg - LEN_W'(1)) begin
               state_next = ST_SAMPLE;
            end else begin
               cnt_next = cnt_reg + LEN_W'(1);
               din_next = sh_reg[0];
               sh_next  = sh_reg >> 1;
            end
         end
         ST_SAMPLE: begin
            result_next = fsm_state;
            match_next  = (fsm_state == exp_reg);
            done_next   = 1'b1;
            state_next  = ST_DONE;
         end
         ST_DONE: begin
            gnt_next   = '0;
            state_next = ST_IDLE;
         end
         default: begin
            gnt_next   = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         gnt_reg    <= '0;
         sh_reg     <= '0;
         len_reg    <= '0;
         cnt_reg    <= '0;
         exp_reg    <= '0;
         result_reg <= '0;
         match_reg  <= 1'b0;
         done_reg   <= 1'b0;
         clr_reg    <= 1'b0;
         din_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         gnt_reg    <= gnt_next;
         sh_reg     <= sh_next;
         len_reg    <= len_next;
         cnt_reg    <= cnt_next;
         exp_reg    <= exp_next;
         result_reg <= result_next;
         match_reg  <= match_next;
         done_reg   <= done_next;
         clr_reg    <= clr_next;
         din_reg    <= din_next;
      end
   end

   assign gnt     = gnt_reg;
   assign busy    = (state_reg != ST_IDLE);
   assign done    = done_reg;
   assign result  = result_reg;
   assign match   = match_reg;
   // Reset term keeps the downstream FSM cleared whenever this block is held in reset
   assign fsm_clr = reset | clr_reg;
   assign fsm_din = din_reg;

endmodule

// File: tb/tb_safe_fsm_sequencer.sv
// Bench for safe_fsm_sequencer: downstream FSM stand-in, transaction-level model with
// per-cycle compare, and directed transactions with hand-computed expectations.
module tb_safe_fsm_sequencer;
   localparam int NREQ  = 2;
   localparam int PAT_W = 8;
   localparam int LEN_W = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*PAT_W-1:0] pat_i;
   logic [NREQ*LEN_W-1:0] len_i;
   logic [NREQ-1:0]       init_i;
   logic [NREQ*2-1:0]     exp_i;
   logic [NREQ-1:0]       gnt;
   logic                  busy, done, match, fsm_clr, fsm_din;
   logic [1:0]            result, fsm_state;

   safe_fsm_sequencer #(.NREQ(NREQ), .PAT_W(PAT_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .req(req), .pat_i(pat_i), .len_i(len_i),
      .init_i(init_i), .exp_i(exp_i), .gnt(gnt), .busy(busy), .done(done),
      .result(result), .match(match), .fsm_clr(fsm_clr), .fsm_din(fsm_din),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // Downstream stand-in: each 1 bit advances S0->S1->S2->S3, saturating; 0 holds
   logic [1:0] ds;
   always @(posedge clk or posedge fsm_clr) begin
      if (fsm_clr) ds <= 2'd0;
      else if (fsm_din && ds != 2'd3) ds <= ds + 2'd1;
   end
   assign fsm_state = ds;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req_v, $time);
      end
   endtask

   typedef struct packed {
      logic [NREQ-1:0] g;
      logic            clr;
      logic            din;
      logic            dn;
      logic [1:0]      res;
      logic            mat;
   } exp_t;

   exp_t       q[$];
   exp_t       cur;
   int         ptr_m = 0;
   logic [1:0] ds_seen = 2'd0;

   task automatic build_txn();
      int w;
      int l;
      logic [PAT_W-1:0] p;
      logic in;
      logic [1:0] e;
      logic [1:0] st;
      exp_t ent;
      w = -1;
      for (int i = 0; i < NREQ; i++)
         if (w < 0 && req[(ptr_m + i) % NREQ]) w = (ptr_m + i) % NREQ;
      ptr_m = (w + 1) % NREQ;
      p  = pat_i[w*PAT_W +: PAT_W];
      l  = int'(len_i[w*LEN_W +: LEN_W]);
      if (l > PAT_W) l = PAT_W;
      in = init_i[w];
      e  = exp_i[w*2 +: 2];
      st = in ? 2'd0 : ds_seen;
      for (int k = 0; k < l; k++)
         if (p[k] && st != 2'd3) st = st + 2'd1;
      ent = '0;
      ent.g = NREQ'(1) << w;
      if (in) begin
         ent.clr = 1'b1;
         q.push_back(ent);
         ent.clr = 1'b0;
      end
      for (int k = 0; k < l; k++) begin
         ent.din = p[k];
         q.push_back(ent);
      end
      ent.din = 1'b0;
      q.push_back(ent);
      ent.dn  = 1'b1;
      ent.res = st;
      ent.mat = (st == e);
      q.push_back(ent);
      q.push_back('0);
   endtask

   initial begin : model_compare
      cur = '0;
      forever begin
         @(posedge clk);
         if (reset) begin
            q.delete();
            cur   = '0;
            ptr_m = 0;
         end else begin
            if (q.size() == 0 && req != '0) build_txn();
            if (q.size() != 0) cur = q.pop_front();
            else cur = '0;
         end
         @(negedge clk);
         chk("gnt", gnt, cur.g);
         chk("busy", busy, |cur.g);
         chk("done", done, cur.dn);
         chk("fsm_clr", fsm_clr, reset | cur.clr);
         chk("fsm_din", fsm_din, cur.din);
         if (cur.dn) begin
            chk("result", result, cur.res);
            chk("match", match, cur.mat);
         end
         ds_seen = ds;
      end
   end

   task automatic run_txn(input int k, input logic [7:0] p, input int l, input logic in,
                          input logic [1:0] e, input int ncyc, input int r, input int m,
                          input int nones);
      int c;
      int ones;
      bit got;
      @(negedge clk);
      #1;
      pat_i[k*PAT_W +: PAT_W] = p;
      len_i[k*LEN_W +: LEN_W] = LEN_W'(l);
      init_i[k]               = in;
      exp_i[k*2 +: 2]         = e;
      req[k]                  = 1'b1;
      c = 0; ones = 0; got = 1'b0;
      while (c < 60 && !got) begin
         @(negedge clk);
         c++;
         if (c == 1) chk("clr_cycle1", fsm_clr, in);
         if (fsm_din) ones++;
         if (done) begin
            got = 1'b1;
            chk("done_gnt", gnt, NREQ'(1) << k);
         end
      end
      chk("latency", c, ncyc);
      chk("txn_result", result, r);
      chk("txn_match", match, m);
      chk("shifted_ones", ones, nones);
      $display("txn req=%0d pat=%02h len=%0d init=%0d -> done cycle %0d result=%0d match=%0d",
               k, p, l, in, c, result, match);
      #1 req[k] = 1'b0;
   endtask

   initial begin : stim
      int ndone;
      int low;
      int cyc;
      reset = 1'b1; req = '0; pat_i = '0; len_i = '0; init_i = '0; exp_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_match", match, 0);
      chk("rst_din", fsm_din, 0);
      chk("rst_clr", fsm_clr, 1);
      #1 reset = 1'b0;

      run_txn(0, 8'h07, 4,  1'b1, 2'd3, 7,  3, 1, 3);
      run_txn(1, 8'h05, 3,  1'b1, 2'd3, 6,  2, 0, 2);
      run_txn(0, 8'h00, 0,  1'b0, 2'd2, 2,  2, 1, 0);
      run_txn(1, 8'hFF, 12, 1'b1, 2'd3, 11, 3, 1, 8);

      // Back-to-back: both requesters held, grants must alternate 0,1,0,1
      @(negedge clk);
      #1;
      pat_i = {8'h03, 8'h01}; len_i = {4'd2, 4'd2}; init_i = 2'b11; exp_i = {2'd2, 2'd1};
      req = 2'b11;
      ndone = 0; low = 0; cyc = 0;
      while (ndone < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            chk("b2b_gnt", gnt, (ndone % 2 == 0) ? 1 : 2);
            $display("b2b txn %0d gnt=%b result=%0d match=%0d", ndone, gnt, result, match);
            ndone++;
            low = 0;
         end else if (gnt == '0) begin
            low++;
         end else if (low != 0) begin
            chk("b2b_gap", low, 1);
            low = 0;
         end
      end
      chk("b2b_count", ndone, 4);
      #1 req = '0;

      // Reset in the second SHIFT cycle of a requester-0 transaction
      @(negedge clk);
      @(negedge clk);
      #1;
      pat_i[7:0] = 8'hAA; len_i[3:0] = 4'd8; init_i[0] = 1'b0; req = 2'b01;
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_clr", fsm_clr, 1);
      req = '0;
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      pat_i = {8'h01, 8'h01}; len_i = {4'd1, 4'd1}; init_i = 2'b11; exp_i = {2'd1, 2'd1};
      req = 2'b11;
      @(negedge clk);
      chk("post_rst_gnt", gnt, 1);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("post_rst_done", done, 1);
      chk("post_rst_result", result, 1);
      $display("post-reset txn gnt=%b result=%0d match=%0d", gnt, result, match);
      #1 req = '0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
